and16_resp_checker: RTL and testbench

Hardware response checker for the 16-bit AND datapath. It is the receiving end of the operand stimulus stream: it samples the (X, Y, OUT) triple each time the stream marks it valid and compares OUT against X & Y. It counts mismatches, records the index of the first failing vector, and compresses every OUT into a MISR signature. After a programmed number of vectors it reports pass/fail, so AND16 and its successors can be self-checked in simulation and on silicon without `$monitor` inspection.

---
 rtl/xiphos_chk_pkg.sv | 21 ++
 rtl/and16_resp_checker_misr16.sv | 28 ++
 rtl/and16_resp_checker.sv | 103 ++++++++++
 tb/tb_and16_resp_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xiphos_chk_pkg.sv
// Shared definitions for the xiphos response checkers: checker state encoding,
// default MISR constants and the 16-bit MISR step.
package xiphos_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] MISR_SEED_DEFAULT = 16'hFFFF;

    // Shift left, fold the dropped MSB back through the polynomial, then mix in the data word.
    function automatic logic [15:0] misr16_step(input logic [15:0] sig,
                                                input logic [15:0] data,
                                                input logic [15:0] poly);
        return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/and16_resp_checker_misr16.sv
// 16-bit multiple-input signature register with synchronous seed load and step enable.
// Shared by the AND16 checker and its ALU/ADD16 successors.
module misr16
    import xiphos_chk_pkg::*;
#(
    parameter logic [15:0] POLY = MISR_POLY_DEFAULT,
    parameter logic [15:0] SEED = MISR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] sig
);

    // Load takes priority so a new run always begins from the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= misr16_step(sig, data, POLY);
        end
    end

endmodule

// File: rtl/and16_resp_checker.sv
// Receiving end of the AND16 operand stream: checks out == x & y for a fixed number
// of vectors, counts mismatches, records the first failing index and signs every result.
module and16_resp_checker
    import xiphos_chk_pkg::*;
#(
    parameter int              WIDTH       = 16,
    parameter int              NUM_VECTORS = 50,
    parameter int              CNT_W       = 16,
    parameter logic [WIDTH-1:0] MISR_POLY  = MISR_POLY_DEFAULT,
    parameter logic [WIDTH-1:0] MISR_SEED  = MISR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] signature
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    chk_state_e       state;
    logic [CNT_W-1:0] vec_cnt;
    logic             launch;
    logic             accept;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;

    // A start seen outside RUN wins over a coincident valid, so that sample is never counted.
    assign launch   = start && (state != RUN);
    assign accept   = valid && (state == RUN);
    assign mismatch = (out != (x & y));
    assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    misr16 #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (launch),
        .en    (accept),
        .data  (out),
        .sig   (signature)
    );

    // Status flags are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vec_cnt       <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        vec_cnt       <= '0;
                        err_count     <= '0;
                        first_err_idx <= '1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                    end
                end
                RUN: begin
                    if (valid) begin
                        err_count <= err_next;
                        if (mismatch && (first_err_idx == '1)) begin
                            first_err_idx <= vec_cnt;
                        end
                        if (vec_cnt == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            vec_cnt <= vec_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and16_resp_checker.sv
// Scoreboard bench for and16_resp_checker: stimulus pushes expected run results,
// monitors pop and compare whenever a checker raises done.
module tb_and16_resp_checker;

    typedef struct packed {
        logic [15:0] err;
        logic [15:0] fei;
        logic        pass;
        logic [15:0] sig;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start1;
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] out;

    logic        busy,  done,  pass;
    logic [15:0] err_count,  first_err_idx,  signature;
    logic        busy1, done1, pass1;
    logic [15:0] err_count1, first_err_idx1, signature1;

    exp_t q[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    logic done_prev  = 1'b0;
    logic done1_prev = 1'b0;

    and16_resp_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .valid         (valid),
        .x             (x),
        .y             (y),
        .out           (out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .signature     (signature)
    );

    and16_resp_checker #(.NUM_VECTORS(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start1),
        .valid         (valid),
        .x             (x),
        .y             (y),
        .out           (out),
        .busy          (busy1),
        .done          (done1),
        .pass          (pass1),
        .err_count     (err_count1),
        .first_err_idx (first_err_idx1),
        .signature     (signature1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        return n ^ d;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_result(input string tag, input exp_t e, input logic [15:0] ec,
                                  input logic [15:0] fe, input logic p, input logic [15:0] s);
        check_output({tag, "_err_count"}, 32'(ec), 32'(e.err));
        check_output({tag, "_first_err_idx"}, 32'(fe), 32'(e.fei));
        check_output({tag, "_pass"}, 32'(p), 32'(e.pass));
        check_output({tag, "_signature"}, 32'(s), 32'(e.sig));
    endtask

    // Monitors: one result per rising edge of done, compared against the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev <= 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done got=1 expected=0");
                end else begin
                    compare_result("run", q.pop_front(), err_count, first_err_idx, pass, signature);
                end
            end
            done_prev <= done;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            done1_prev <= 1'b0;
        end else begin
            if (done1 && !done1_prev) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done1 got=1 expected=0");
                end else begin
                    compare_result("nv1", q1.pop_front(), err_count1, first_err_idx1, pass1, signature1);
                end
            end
            done1_prev <= done1;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Stream vector i: x = i, y = 5*i, out = x & y with bit 0 flipped on indices e1/e2.
    task automatic apply_stimulus(input int n, input int e1, input int e2,
                                  input bit gaps, input bit poke, input bit push);
        exp_t        e;
        logic [15:0] vx, vy, vo;
        e.err  = 16'h0000;
        e.fei  = 16'hFFFF;
        e.sig  = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            vx = 16'(i);
            vy = 16'(5 * i);
            vo = vx & vy;
            if (i == e1 || i == e2) vo[0] = ~vo[0];
            if (vo != (vx & vy)) begin
                e.err = e.err + 16'd1;
                if (e.fei == 16'hFFFF) e.fei = 16'(i);
            end
            e.sig = model_step(e.sig, vo);
        end
        e.pass = (e.err == 16'h0000);
        if (push) q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    valid = 1'b0;
                    start = poke;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            x  = 16'(i);
            y  = 16'(5 * i);
            out = x & y;
            if (i == e1 || i == e2) out[0] = ~out[0];
            valid = 1'b1;
            start = poke && (i % 3 == 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        check_output(name, 32'(done), 32'd1);
    endtask

    initial begin
        exp_t e1;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; valid = 1'b0;
        x = '0; y = '0; out = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_pass", 32'(pass), 32'd0);
        check_output("rst_err_count", 32'(err_count), 32'd0);
        check_output("rst_first_err_idx", 32'(first_err_idx), 32'hFFFF);
        check_output("rst_signature", 32'(signature), 32'hFFFF);

        // Single-vector run on the NUM_VECTORS=1 instance; the default instance sits in IDLE.
        e1.err = 16'h0000; e1.fei = 16'hFFFF; e1.pass = 1'b1; e1.sig = 16'hEFD0;
        q1.push_back(e1);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        x = 16'h00FF; y = 16'h0F0F; out = 16'h000F; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check_output("nv1_done", 32'(done1), 32'd1);
        check_output("idle_valid_sig", 32'(signature), 32'hFFFF);
        check_output("idle_valid_busy", 32'(busy), 32'd0);

        $display("[TB] gap-free run");
        pulse_start();
        check_output("start_busy", 32'(busy), 32'd1);
        apply_stimulus(50, -1, -1, 1'b0, 1'b0, 1'b1);
        wait_done("gapfree_done");
        check_output("gapfree_busy", 32'(busy), 32'd0);

        $display("[TB] error-injection run");
        pulse_start();
        apply_stimulus(50, 7, 20, 1'b0, 1'b0, 1'b1);
        wait_done("errrun_done");
        check_output("errrun_count", 32'(err_count), 32'd2);
        check_output("errrun_first", 32'(first_err_idx), 32'd7);
        check_output("errrun_pass", 32'(pass), 32'd0);

        $display("[TB] gapped run with start pokes");
        pulse_start();
        apply_stimulus(50, -1, -1, 1'b1, 1'b1, 1'b1);
        wait_done("gapped_done");
        check_output("nv1_sig_held", 32'(signature1), 32'hEFD0);

        $display("[TB] mid-run reset");
        pulse_start();
        apply_stimulus(10, 7, -1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_err_count", 32'(err_count), 32'd0);
        check_output("midrst_first_err_idx", 32'(first_err_idx), 32'hFFFF);
        check_output("midrst_signature", 32'(signature), 32'hFFFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        x = 16'h1234; y = 16'h00FF; out = 16'hFFFF; valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check_output("postrst_busy", 32'(busy), 32'd0);
        check_output("postrst_err_count", 32'(err_count), 32'd0);
        check_output("postrst_signature", 32'(signature), 32'hFFFF);

        $display("[TB] restart from DONE with coincident valid");
        pulse_start();
        apply_stimulus(50, -1, -1, 1'b0, 1'b0, 1'b1);
        wait_done("rerun_done");
        start = 1'b1; valid = 1'b1; x = 16'h0001; y = 16'h0001; out = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b0;
        check_output("restart_busy", 32'(busy), 32'd1);
        check_output("restart_done", 32'(done), 32'd0);
        check_output("restart_err_count", 32'(err_count), 32'd0);
        check_output("restart_signature", 32'(signature), 32'hFFFF);
        apply_stimulus(50, -1, -1, 1'b0, 1'b0, 1'b1);
        wait_done("restart_run_done");

        @(posedge clk); #1;
        check_output("queue_drained", 32'(q.size()), 32'd0);
        check_output("queue1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
